// File: rtl/and3_sweep_ctrl_if.sv
// and3_sweep_ctrl_if: button, gate and status signals between the AND3 sweep controller and its surroundings.
interface and3_sweep_ctrl_if;
  logic       start_i;
  logic       abort_i;
  logic       gate_c_i;
  logic       gate_a_o;
  logic       gate_b_o;
  logic       gate_d_o;
  logic [2:0] vector_o;
  logic       busy_o;
  logic       done_o;
  logic       pass_o;
  logic [3:0] fail_count_o;
  logic [2:0] fail_vector_o;
  modport master (
    input  start_i, abort_i, gate_c_i,
    output gate_a_o, gate_b_o, gate_d_o, vector_o, busy_o, done_o, pass_o, fail_count_o, fail_vector_o
  );
  modport slave (
    output start_i, abort_i, gate_c_i,
    input  gate_a_o, gate_b_o, gate_d_o, vector_o, busy_o, done_o, pass_o, fail_count_o, fail_vector_o
  );
endinterface

// File: rtl/and3_sweep_ctrl.sv
// and3_sweep_ctrl: steps a 3-input AND gate through all 8 vectors and checks its output.
// AND3_SWEEP_STOP_ON_FAIL_EN: end the sweep after the dwell of the first failing vector.
module and3_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DWELL_CYCLES  = 12_000_000
) (
  input logic                 clk_12mhz_i,
  input logic                 reset_n_i,
  and3_sweep_ctrl_if.master   bus
);
  localparam int MAX_CYCLES = SETTLE_CYCLES > DWELL_CYCLES ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] S_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] D_END = CW'(DWELL_CYCLES - 1);
  localparam logic [2:0] IDLE = 3'd0, APPLY = 3'd1, SAMPLE = 3'd2, DWELL = 3'd3, DONE = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    vec_q, vec_d;
  logic [3:0]    fc_q, fc_d;
  logic [2:0]    fv_q, fv_d;
  logic          start_q, abort_q, busy_q, done_q, pass_q;
  logic          go, mismatch, last;
`ifdef AND3_SWEEP_STOP_ON_FAIL_EN
  assign last = (vec_q == 3'd7) || (fc_q != 4'd0);
`else
  assign last = vec_q == 3'd7;
`endif
  // A start edge coinciding with a pending abort is consumed without starting.
  assign go = bus.start_i & ~start_q & ~bus.abort_i & ~abort_q;
  assign mismatch = bus.gate_c_i != (vec_q == 3'd7);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    vec_d = vec_q;
    fc_d = fc_q;
    fv_d = fv_q;
    case (state_q)
      IDLE, DONE: if (go) begin
        state_d = APPLY;
        cnt_d = '0;
        vec_d = '0;
        fc_d = '0;
        fv_d = '0;
      end
      APPLY: begin
        state_d = cnt_q == S_END ? SAMPLE : APPLY;
        cnt_d = cnt_q == S_END ? '0 : cnt_q + 1'b1;
      end
      SAMPLE: begin
        state_d = DWELL;
        fc_d = fc_q + {3'd0, mismatch};
        fv_d = mismatch && fc_q == 4'd0 ? vec_q : fv_q;
      end
      DWELL: begin
        state_d = cnt_q == D_END ? (last ? DONE : APPLY) : DWELL;
        cnt_d = cnt_q == D_END ? '0 : cnt_q + 1'b1;
        vec_d = cnt_q == D_END && !last ? vec_q + 3'd1 : vec_q;
      end
      default: state_d = IDLE;
    endcase
    if (abort_q && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d = '0;
      vec_d = '0;
      fc_d = '0;
      fv_d = '0;
    end
  end
  always_ff @(posedge clk_12mhz_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vec_q <= '0;
      fc_q <= '0;
      fv_q <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      fc_q <= fc_d;
      fv_q <= fv_d;
      start_q <= bus.start_i;
      abort_q <= bus.abort_i;
      busy_q <= state_d == APPLY || state_d == SAMPLE || state_d == DWELL;
      done_q <= state_d == DONE;
      pass_q <= state_d == DONE && fc_d == 4'd0;
    end
  end
  assign bus.gate_a_o = vec_q[0];
  assign bus.gate_b_o = vec_q[1];
  assign bus.gate_d_o = vec_q[2];
  assign bus.vector_o = vec_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.pass_o = pass_q;
  assign bus.fail_count_o = fc_q;
  assign bus.fail_vector_o = fv_q;
endmodule
